// File: rtl/wb2axi_ddr_bridge.sv
// Wishbone B3 slave to AXI4 master bridge for the board DDR port; one transaction in flight.
// Optional macro WB2AXI_BURST_EN: serve cti=3'b010 linear reads as a single buffered AXI burst.
module wb2axi_ddr_bridge #(
   parameter logic [3:0] AXI_ID     = 4'h0,
   parameter int         ADDR_WIDTH = 28,
   parameter int         BURST_LEN  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_we_i,
   input  logic [31:0]           wb_adr_i,
   input  logic [31:0]           wb_dat_i,
   input  logic [3:0]            wb_sel_i,
   input  logic [2:0]            wb_cti_i,
   input  logic [1:0]            wb_bte_i,
   output logic [31:0]           wb_dat_o,
   output logic                  wb_ack_o,
   output logic                  wb_err_o,
   output logic [3:0]            m_axi_awid,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic [3:0]            m_axi_awqos,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [31:0]           m_axi_wdata,
   output logic [3:0]            m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [3:0]            m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [3:0]            m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic [3:0]            m_axi_arqos,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [3:0]            m_axi_rid,
   input  logic [31:0]           m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   output logic [2:0]            dbg_state
);

   // Every AXI channel transfers on a rising edge where valid and ready are both high; once
   // raised, a valid (and its payload) stays put until that edge, whatever Wishbone does.
   typedef enum logic [2:0] {
      IDLE = 3'd0, WR = 3'd1, WR_RESP = 3'd2, RD_ADDR = 3'd3,
      RD_DATA = 3'd4, DONE = 3'd5, RD_BURST = 3'd6, DRAIN = 3'd7
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  abort_q;
   logic                  req;
   logic                  live;
   logic                  wr_ok;
   logic                  rd_ok;

   assign req   = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
   assign live  = wb_cyc_i & ~abort_q;
   assign wr_ok = (m_axi_bresp == 2'b00) && (m_axi_bid == AXI_ID);
   assign rd_ok = (m_axi_rresp == 2'b00) && (m_axi_rid == AXI_ID);
   assign dbg_state = state;

   assign m_axi_awid    = AXI_ID;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = 8'd0;
   assign m_axi_awsize  = 3'b010;
   assign m_axi_awburst = 2'b01;
   assign m_axi_awcache = 4'b0011;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awqos   = 4'b0000;
   assign m_axi_wlast   = 1'b1;
   assign m_axi_arid    = AXI_ID;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arsize  = 3'b010;
   assign m_axi_arburst = 2'b01;
   assign m_axi_arcache = 4'b0011;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arqos   = 4'b0000;

`ifdef WB2AXI_BURST_EN
   localparam int LG = $clog2(BURST_LEN);

   logic [LG:0]           wr_cnt;
   logic [LG:0]           rd_cnt;
   logic [31:0]           buf_q [BURST_LEN];
   logic [BURST_LEN-1:0]  bad_q;
   logic                  burst_q;
   logic [7:0]            arlen_q;
   logic [ADDR_WIDTH-3:0] beat_adr;
   logic                  beat_in;
   logic                  unused;

   assign m_axi_arlen = arlen_q;
   assign beat_adr    = addr_q[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(rd_cnt);
   assign beat_in     = (state == RD_BURST) & m_axi_rvalid & m_axi_rready;
   assign unused      = ^{wb_adr_i[31:ADDR_WIDTH], wb_adr_i[1:0]};

   always_ff @(posedge clk) begin
      if (beat_in) begin
         buf_q[wr_cnt[LG-1:0]] <= m_axi_rdata;
         bad_q[wr_cnt[LG-1:0]] <= ~rd_ok;
      end
   end
`else
   logic unused;

   assign m_axi_arlen = 8'd0;
   assign unused      = ^{wb_adr_i[31:ADDR_WIDTH], wb_adr_i[1:0], wb_cti_i, wb_bte_i, 8'(BURST_LEN)};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         addr_q        <= '0;
         abort_q       <= 1'b0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         wb_ack_o      <= 1'b0;
         wb_err_o      <= 1'b0;
         wb_dat_o      <= '0;
`ifdef WB2AXI_BURST_EN
         burst_q       <= 1'b0;
         arlen_q       <= '0;
         wr_cnt        <= '0;
         rd_cnt        <= '0;
`endif
      end else begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         // A dropped cycle only mutes the completion pulse; the AXI side still finishes.
         if (state != IDLE && !wb_cyc_i) abort_q <= 1'b1;
         case (state)
            IDLE: if (req) begin
               addr_q      <= {wb_adr_i[ADDR_WIDTH-1:2], 2'b00};
               m_axi_wdata <= wb_dat_i;
               m_axi_wstrb <= wb_sel_i;
               abort_q     <= 1'b0;
               if (wb_we_i) begin
                  m_axi_awvalid <= 1'b1;
                  m_axi_wvalid  <= 1'b1;
                  state         <= WR;
               end else begin
                  m_axi_arvalid <= 1'b1;
                  state         <= RD_ADDR;
`ifdef WB2AXI_BURST_EN
                  burst_q <= (wb_cti_i == 3'b010) && (wb_bte_i == 2'b00);
                  arlen_q <= ((wb_cti_i == 3'b010) && (wb_bte_i == 2'b00)) ?
                             8'(BURST_LEN - 1) - 8'(wb_adr_i[LG+1:2]) : 8'd0;
                  wr_cnt  <= '0;
                  rd_cnt  <= '0;
`endif
               end
            end
            WR: begin
               if (m_axi_awready) m_axi_awvalid <= 1'b0;
               if (m_axi_wready) m_axi_wvalid <= 1'b0;
               if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                  m_axi_bready <= 1'b1;
                  state        <= WR_RESP;
               end
            end
            WR_RESP: if (m_axi_bvalid) begin
               m_axi_bready <= 1'b0;
               wb_ack_o     <= live & wr_ok;
               wb_err_o     <= live & ~wr_ok;
               state        <= DONE;
            end
            RD_ADDR: if (m_axi_arready) begin
               m_axi_arvalid <= 1'b0;
               m_axi_rready  <= 1'b1;
`ifdef WB2AXI_BURST_EN
               state <= burst_q ? RD_BURST : RD_DATA;
`else
               state <= RD_DATA;
`endif
            end
            RD_DATA: if (m_axi_rvalid && m_axi_rlast) begin
               m_axi_rready <= 1'b0;
               wb_dat_o     <= m_axi_rdata;
               wb_ack_o     <= live & rd_ok;
               wb_err_o     <= live & ~rd_ok;
               state        <= DONE;
            end
            DONE: state <= IDLE;
`ifdef WB2AXI_BURST_EN
            RD_BURST: begin
               if (beat_in) begin
                  wr_cnt <= wr_cnt + 1'b1;
                  if (m_axi_rlast) m_axi_rready <= 1'b0;
               end
               // One ack per Wishbone beat; the cycle after an ack still shows the old address.
               if (!wb_cyc_i) state <= DRAIN;
               else if (wb_stb_i && !wb_ack_o && !wb_err_o) begin
                  if (wb_we_i || wb_adr_i[ADDR_WIDTH-1:2] != beat_adr) state <= DRAIN;
                  else if (rd_cnt < wr_cnt) begin
                     wb_dat_o <= buf_q[rd_cnt[LG-1:0]];
                     wb_ack_o <= ~bad_q[rd_cnt[LG-1:0]];
                     wb_err_o <= bad_q[rd_cnt[LG-1:0]];
                     rd_cnt   <= rd_cnt + 1'b1;
                     if (wb_cti_i == 3'b111 || 8'(rd_cnt) == arlen_q) state <= DRAIN;
                  end
               end
            end
            DRAIN: if (!m_axi_rready || (m_axi_rvalid && m_axi_rlast)) begin
               m_axi_rready <= 1'b0;
               state        <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb2axi_ddr_bridge.sv
// Directed bench for wb2axi_ddr_bridge: Wishbone master driver, cycle-stepped AXI slave, data scoreboard.
module tb_wb2axi_ddr_bridge;

   localparam int AW = 28;
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WR_RESP = 3'd2;
   localparam logic [2:0] ST_RD_DATA = 3'd4;

   logic clk = 1'b0;
   logic rst;
   logic wb_cyc_i, wb_stb_i, wb_we_i;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic [3:0] wb_sel_i;
   logic [2:0] wb_cti_i;
   logic [1:0] wb_bte_i;
   logic wb_ack_o, wb_err_o;
   logic [3:0] m_axi_awid, m_axi_awcache, m_axi_awqos, m_axi_arid, m_axi_arcache, m_axi_arqos;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic [7:0] m_axi_awlen, m_axi_arlen;
   logic [2:0] m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
   logic [1:0] m_axi_awburst, m_axi_arburst;
   logic m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
   logic [31:0] m_axi_wdata, m_axi_rdata;
   logic [3:0] m_axi_wstrb, m_axi_bid, m_axi_rid;
   logic m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic [1:0] m_axi_bresp, m_axi_rresp;
   logic m_axi_bvalid, m_axi_bready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
   logic [2:0] dbg_state;

   wb2axi_ddr_bridge dut (
      .clk(clk), .rst(rst),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
      .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
      .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
      .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // slave configuration and observations
   int aw_wait, w_wait, b_wait, ar_wait, r_wait;
   int aw_ctr, w_ctr, b_ctr, ar_ctr, r_ctr;
   int aw_hs, w_hs, b_hs, ar_hs, r_hs, r_left;
   bit aw_done, w_done, b_armed, cur_rd;
   logic [1:0] bresp_cfg, rresp_cfg;
   logic [3:0] bid_cfg, rid_cfg;
   logic [31:0] rdata_cfg;
   logic [AW-1:0] awaddr_seen, araddr_seen;
   logic [7:0] awlen_seen, arlen_seen;
   logic [31:0] wdata_seen;
   logic [3:0] wstrb_seen;
   logic wlast_seen;
   int k, b_k, ack_k, ack_cnt, err_cnt;
   int n_checks, n_pass;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic slave_clear();
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 0;
      m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rid = 0;
      aw_ctr = 0; w_ctr = 0; b_ctr = 0; ar_ctr = 0; r_ctr = 0; r_left = 0;
      aw_done = 0; w_done = 0; b_armed = 0;
   endtask

   // AXI slave, called once per cycle just after the falling edge
   task automatic slave_step();
      if (aw_done && w_done) begin b_armed = 1; aw_done = 0; w_done = 0; end
      m_axi_bvalid = 0;
      if (b_armed && m_axi_bready) begin
         if (b_ctr >= b_wait) begin
            m_axi_bvalid = 1; m_axi_bresp = bresp_cfg; m_axi_bid = bid_cfg;
            b_hs++; b_k = k; b_armed = 0; b_ctr = 0;
         end else b_ctr++;
      end
      m_axi_rvalid = 0; m_axi_rlast = 0;
      if (r_left > 0 && m_axi_rready) begin
         if (r_ctr >= r_wait) begin
            m_axi_rvalid = 1; m_axi_rdata = rdata_cfg; m_axi_rresp = rresp_cfg; m_axi_rid = rid_cfg;
            m_axi_rlast = (r_left == 1); r_left--; r_hs++; r_ctr = 0;
         end else r_ctr++;
      end
      m_axi_awready = 0;
      if (m_axi_awvalid) begin
         if (aw_ctr >= aw_wait) begin
            m_axi_awready = 1; aw_hs++; awaddr_seen = m_axi_awaddr; awlen_seen = m_axi_awlen;
            aw_done = 1; aw_ctr = 0;
         end else aw_ctr++;
      end
      m_axi_wready = 0;
      if (m_axi_wvalid) begin
         if (w_ctr >= w_wait) begin
            m_axi_wready = 1; w_hs++; wdata_seen = m_axi_wdata; wstrb_seen = m_axi_wstrb;
            wlast_seen = m_axi_wlast; w_done = 1; w_ctr = 0;
         end else w_ctr++;
      end
      m_axi_arready = 0;
      if (m_axi_arvalid) begin
         if (ar_ctr >= ar_wait) begin
            m_axi_arready = 1; ar_hs++; araddr_seen = m_axi_araddr; arlen_seen = m_axi_arlen;
            r_left = int'(m_axi_arlen) + 1; ar_ctr = 0;
         end else ar_ctr++;
      end
   endtask

   // one clock: edge, then slave response and Wishbone monitor on the falling edge
   task automatic tick();
      @(posedge clk);
      k++;
      @(negedge clk);
      slave_step();
      if (wb_ack_o) begin
         ack_cnt++; ack_k = k;
         if (cur_rd && exp_q.size() > 0) check("rd_data", wb_dat_o, exp_q.pop_front());
      end
      if (wb_err_o) err_cnt++;
      if (wb_ack_o || wb_err_o) begin wb_cyc_i = 0; wb_stb_i = 0; end
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic wb_start(input bit we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      ack_cnt = 0; err_cnt = 0; ack_k = 0; b_k = 0; k = 1;
      cur_rd = !we;
      wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
      wb_cyc_i = 1; wb_stb_i = 1;
   endtask

   initial begin
      n_checks = 0; n_pass = 0;
      rst = 1;
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_dat_i = 0;
      wb_sel_i = 0; wb_cti_i = 0; wb_bte_i = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      bresp_cfg = 0; rresp_cfg = 0; bid_cfg = 0; rid_cfg = 0; rdata_cfg = 0;
      slave_clear();
      repeat (2) @(negedge clk);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check("rst_outs", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                             m_axi_rready, wb_ack_o, wb_err_o}), 32'd0);
      check("rst_dat", wb_dat_o, 32'd0);
      rst = 0;

      // write with AW delayed by 3 cycles
      aw_wait = 3;
      wb_start(1, 32'h0000_1004, 32'hDEADBEEF, 4'b0011);
      run(20);
      aw_wait = 0;
      check("wr_aw_cnt", aw_hs, 1);
      check("wr_awaddr", 32'(awaddr_seen), 32'h1004);
      check("wr_awlen", 32'(awlen_seen), 0);
      check("wr_w_cnt", w_hs, 1);
      check("wr_wdata", wdata_seen, 32'hDEADBEEF);
      check("wr_wstrb", 32'(wstrb_seen), 32'h3);
      check("wr_wlast", 32'(wlast_seen), 1);
      check("wr_b_cnt", b_hs, 1);
      check("wr_ack_cnt", ack_cnt, 1);
      check("wr_err_cnt", err_cnt, 0);
      check("wr_ack_after_b", 32'(ack_k > b_k), 1);
      check("aw_const", 32'({m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awprot, m_axi_awqos}),
            32'({4'h0, 3'b010, 2'b01, 4'b0011, 3'b000, 4'b0000}));

      // zero-wait read: capture, AR, R, DONE
      rdata_cfg = 32'h12345678;
      wb_start(0, 32'h0000_0010, 32'h0, 4'hF);
      exp_q.push_back(32'h12345678);
      run(20);
      check("rd_araddr", 32'(araddr_seen), 32'h10);
      check("rd_arlen", 32'(arlen_seen), 0);
      check("rd_ack_cnt", ack_cnt, 1);
      check("rd_err_cnt", err_cnt, 0);
      check("rd_latency", ack_k, 4);
      check("ar_const", 32'({m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot, m_axi_arqos}),
            32'({4'h0, 3'b010, 2'b01, 4'b0011, 3'b000, 4'b0000}));

      // write with W delayed; read data must stay on wb_dat_o
      w_wait = 2;
      wb_start(1, 32'h0000_2008, 32'h0BADF00D, 4'b1100);
      run(20);
      w_wait = 0;
      check("wr2_awaddr", 32'(awaddr_seen), 32'h2008);
      check("wr2_wstrb", 32'(wstrb_seen), 32'hC);
      check("wr2_ack_cnt", ack_cnt, 1);
      check("dat_hold", wb_dat_o, 32'h12345678);

      // SLVERR read
      rresp_cfg = 2'b10; rdata_cfg = 32'hCAFE0001;
      wb_start(0, 32'h0000_0040, 32'h0, 4'hF);
      run(20);
      rresp_cfg = 0;
      check("slverr_err_cnt", err_cnt, 1);
      check("slverr_ack_cnt", ack_cnt, 0);

      // write answered with a foreign BID
      bid_cfg = 4'h5;
      wb_start(1, 32'h0000_0044, 32'h1, 4'hF);
      run(20);
      bid_cfg = 0;
      check("bid_err_cnt", err_cnt, 1);
      check("bid_ack_cnt", ack_cnt, 0);

      // cyc dropped while waiting for R
      r_wait = 3; rdata_cfg = 32'h11112222;
      wb_start(0, 32'h0000_0020, 32'h0, 4'hF);
      for (int i = 0; i < 20; i++) begin
         if (dbg_state == ST_RD_DATA) break;
         tick();
      end
      check("abort_reach_rd_data", 32'(dbg_state), 32'(ST_RD_DATA));
      wb_cyc_i = 0; wb_stb_i = 0;
      run(12);
      r_wait = 0;
      check("abort_r_cnt", r_hs, 1);
      check("abort_ack_cnt", ack_cnt, 0);
      check("abort_err_cnt", err_cnt, 0);
      check("abort_idle", 32'(dbg_state), 32'(ST_IDLE));

      rdata_cfg = 32'hA5A50F0F;
      wb_start(0, 32'h0000_0024, 32'h0, 4'hF);
      exp_q.push_back(32'hA5A50F0F);
      run(20);
      check("post_abort_ack_cnt", ack_cnt, 1);

      // asynchronous reset while waiting for B
      b_wait = 1000;
      wb_start(1, 32'h0000_3000, 32'h55AA55AA, 4'hF);
      for (int i = 0; i < 20; i++) begin
         if (dbg_state == ST_WR_RESP) break;
         tick();
      end
      check("rst_reach_wr_resp", 32'(dbg_state), 32'(ST_WR_RESP));
      #2 rst = 1;
      #1;
      check("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check("async_rst_outs", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                                   m_axi_rready, wb_ack_o, wb_err_o}), 32'd0);
      check("async_rst_dat", wb_dat_o, 32'd0);
      wb_cyc_i = 0; wb_stb_i = 0;
      slave_clear();
      b_wait = 0;
      @(negedge clk);
      rst = 0;
      @(negedge clk);

      wb_start(1, 32'h0000_3004, 32'h600DCAFE, 4'b0101);
      run(20);
      check("post_rst_awaddr", 32'(awaddr_seen), 32'h3004);
      check("post_rst_wdata", wdata_seen, 32'h600DCAFE);
      check("post_rst_ack_cnt", ack_cnt, 1);
      check("post_rst_err_cnt", err_cnt, 0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/wb2axi_ddr_bridge.md
Name: wb2axi_ddr_bridge

Overview:
Wishbone B3 slave to AXI4 master bridge placed directly upstream of the board DDR port. The system interconnect issues 32-bit Wishbone accesses; the bridge converts them to AXI4 transactions on the ddr_aw*/w*/b*/ar*/r* channels of the Nexys 4 DDR board abstraction. It runs in the sys_clk domain, which is the MIG UI clock. Only one transaction is outstanding at a time.

Parameters:
AXI_ID, 4'h0, constant ID driven on awid/arid; responses with any other ID are treated as errors.
ADDR_WIDTH, 28, AXI byte-address width; equals the DDR port width.
BURST_LEN, 8, maximum read burst length in beats; must be a power of 2, 2..16; used only with the optional feature.

Ports:
clk  in  1  system clock (sys_clk)
rst  in  1  asynchronous, active-high reset (sys_rst)
wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle, strobe, write enable
wb_adr_i  in  32  byte address; only [ADDR_WIDTH-1:2] used
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects
wb_cti_i  in  3  cycle type (only 3'b010 is honoured, and only with the optional feature)
wb_bte_i  in  2  burst type (only 2'b00 linear is supported)
wb_dat_o  out  32  read data
wb_ack_o, wb_err_o  out  1 each  single-cycle completion pulses
m_axi_aw*  out  AW channel: id 4, addr ADDR_WIDTH, len 8, size 3, burst 2, cache 4, prot 3, qos 4, valid 1; awready is an input of width 1
m_axi_w*  out  W channel: data 32, strb 4, last 1, valid 1; wready is an input of width 1
m_axi_b*  in  B channel: id 4, resp 2, valid 1; bready is an output of width 1
m_axi_ar*  out  AR channel: same fields as AW; arready is an input of width 1
m_axi_r*  in  R channel: id 4, data 32, resp 2, last 1, valid 1; rready is an output of width 1

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - All valid outputs 0; bready/rready 0.
  - wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
  - Reset mid-transaction abandons it with no drain; the MIG is reset by the same sys_rst.
- Constant AXI fields:
  - size=3'b010, burst=2'b01 (INCR), cache=4'b0011, prot=0, qos=0, id=AXI_ID.
  - addr={wb_adr_i[ADDR_WIDTH-1:2],2'b00}.
  - awlen=0. arlen=0 unless a burst read is in progress.
- Request capture: in IDLE, a request is cyc&stb&!ack&!err. Address, data, sel and we are registered on the capture cycle.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE, on a request:
  - we=1 goes to WR; awvalid and wvalid are asserted together on the next cycle.
  - we=0 goes to RD_ADDR with arvalid=1.
- WR:
  - awvalid and wvalid are each held until their own ready is seen. Either may complete first; both may complete in the same cycle.
  - wstrb=sel, wlast=1.
  - When both are done, go to WR_RESP with bready=1.
- WR_RESP: on bvalid, capture bresp and bid, drop bready, go to DONE.
- RD_ADDR: hold arvalid until arready, then go to RD_DATA with rready=1.
- RD_DATA: on rvalid&rlast, capture rdata, rresp and rid, drop rready, go to DONE.
- DONE:
  - Pulse for exactly one cycle: wb_ack_o if resp==2'b00 and id==AXI_ID, otherwise wb_err_o.
  - wb_dat_o holds the captured rdata and is stable until the next read completes.
  - Return to IDLE.
- Latency: minimum request-to-ack is 4 cycles for a read (capture, AR, R, DONE) when AXI responds with zero wait states.
- Wishbone abort: if cyc drops before DONE, the AXI transaction still completes. The ack/err pulse is suppressed and the bridge returns to IDLE.
- Valid stability: AXI valids never deassert before their handshake, regardless of the Wishbone side.
- wb_bte_i!=0 together with wb_cti_i=3'b010 is served as single transfers (classic cycles).

Optional Feature:
Macro WB2AXI_BURST_EN.
- Defined:
  - A read with cti=3'b010 and bte=2'b00 issues one AR with arlen = BURST_LEN-1-adr[log2(BURST_LEN)+1:2]. The burst therefore never crosses a BURST_LEN*4-byte boundary.
  - R beats are written into a BURST_LEN-deep buffer.
  - Each following Wishbone beat whose address equals the previous address+4 is acked on the first cycle that its beat is present in the buffer. At most one ack is issued per cycle.
  - The burst ends when the master signals cti=3'b111, when cyc drops, or when the buffer is exhausted.
  - Any beats still outstanding are drained with rready=1 and discarded before returning to IDLE.
  - A non-OKAY beat gives wb_err_o for that beat only.
- Undefined: all reads are single-beat (arlen=0); no buffer logic is generated.

Test Plan:
- Write adr=0x0000_1004, dat=0xDEADBEEF, sel=4'b0011, with awready delayed 3 cycles and wready immediate -> one AW at addr 0x1004 with len 0, one W with strb 4'b0011 and wlast=1, exactly one wb_ack_o pulse after bvalid.
- Read adr=0x0000_0010 with the slave returning rdata=0x12345678, rresp=OKAY -> arlen=0, wb_dat_o=0x12345678, one ack pulse, 4 cycles total at zero wait states.
- Read answered with rresp=2'b10 (SLVERR), and separately a write answered with bid!=AXI_ID -> wb_err_o pulses once each, no wb_ack_o.
- cyc dropped during RD_DATA -> R beat still accepted, no ack/err pulse, next request served normally.
- rst asserted during WR_RESP -> outputs reach reset values without waiting for a clock edge, state=IDLE, next write completes correctly.
- [WB2AXI_BURST_EN, BURST_LEN=8] cti=010 read starting at 0x18 -> arlen=1; 2 acks with the correct data. Then a burst at 0x00 ended with cti=111 after 3 beats -> 8 R beats accepted, 3 acks, 5 beats discarded, bridge returns to IDLE.
